// File: rtl/opl3_reg_write_queue_pkg.sv
// Shared types for the OPL3 register write path.
//   PKG_DATA_WIDTH / PKG_DEPTH : default register data width and address space
//   REG_ADDR_WIDTH             : register address width ($clog2 of the address space)
//   reg_write_t                : one queued register write {addr, data}
//   state_t                    : write-queue FSM states
// The struct widths come from these constants. The top-level DATA_WIDTH/DEPTH
// parameters must keep the same values as the constants here.
package opl3_pkg;

    localparam int PKG_DATA_WIDTH = 8;
    localparam int PKG_DEPTH      = 512;
    localparam int REG_ADDR_WIDTH = $clog2(PKG_DEPTH);

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] addr;
        logic [PKG_DATA_WIDTH-1:0] data;
    } reg_write_t;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/opl3_reg_write_queue_if.sv
// Host write handshake and register-memory write port.
//   host_wr_valid/host_wr_ready/host_addr/host_data : host register write request
//   wea/addra/dia                                   : registered memory write port
// The slave modport is the write queue. The master modport is the host/memory side.
interface opl3_reg_write_queue_if #(
    parameter int AW = 9,
    parameter int DW = 8
);
    logic          host_wr_valid;
    logic          host_wr_ready;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_data;
    logic          wea;
    logic [AW-1:0] addra;
    logic [DW-1:0] dia;

    modport slave (
        input  host_wr_valid, host_addr, host_data,
        output host_wr_ready, wea, addra, dia
    );

    modport master (
        output host_wr_valid, host_addr, host_data,
        input  host_wr_ready, wea, addra, dia
    );
endinterface

// File: rtl/opl3_reg_write_queue_fifo.sv
// Synchronous FIFO of register writes.
//   clk, reset_n : clock and async active-low reset (pointers only)
//   push, din    : enqueue. Ignored while full.
//   pop, dout    : dequeue. dout always shows the head entry.
//   full, empty, level : occupancy status
module reg_write_fifo
    import opl3_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             push,
    input  reg_write_t                       din,
    input  logic                             pop,
    output reg_write_t                       dout,
    output logic                             full,
    output logic                             empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] level
);
    localparam int PW = $clog2(FIFO_DEPTH);

    reg_write_t mem [FIFO_DEPTH];
    // The extra MSB on each pointer separates full from empty when the indexes are equal.
    logic [PW:0] wr_ptr, rd_ptr;
    logic        do_push, do_pop;

    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == (PW+1)'(FIFO_DEPTH));
    assign empty   = (wr_ptr == rd_ptr);
    assign dout    = mem[rd_ptr[PW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= din;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/opl3_reg_write_queue.sv
// Register-file write front end. It buffers host writes and issues at most one
// memory write per drain_en cycle. It sweeps all addresses to CLEAR_VALUE after
// reset or on clear_req.
//   clk, reset_n : clock and async active-low reset
//   bus          : host handshake (valid/ready/addr/data) and memory port (wea/addra/dia)
//   drain_en     : memory write slot allowed this cycle
//   clear_req    : single-cycle pulse that (re)starts a clear sweep
//   busy         : sweep in progress. Stays high through the last sweep write.
//   overflow     : sticky flag for a write offered while the FIFO was full
//   fifo_level   : FIFO occupancy
module opl3_reg_write_queue
    import opl3_pkg::*;
#(
    parameter int                    DATA_WIDTH  = PKG_DATA_WIDTH,
    parameter int                    DEPTH       = PKG_DEPTH,
    parameter int                    FIFO_DEPTH  = 16,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                             clk,
    input  logic                             reset_n,
    opl3_reg_write_queue_if.slave            bus,
    input  logic                             drain_en,
    input  logic                             clear_req,
    output logic                             busy,
    output logic                             overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);
    localparam int AW = $clog2(DEPTH);

    state_t                state_q, state_d;
    logic [AW-1:0]         cnt_q, cnt_d;
    logic                  ovf_q, ovf_d;
    logic                  busy_q, busy_d;
    logic                  wea_q, wea_d;
    logic [AW-1:0]         addra_q, addra_d;
    logic [DATA_WIDTH-1:0] dia_q, dia_d;

    reg_write_t head, push_ent;
    logic       full, empty, push, pop;

    // Ready comes only from the registered full flag, so a pop in the same cycle does not free a slot.
    assign push     = bus.host_wr_valid && !full;
    assign push_ent = '{addr: bus.host_addr, data: bus.host_data};

    reg_write_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .din     (push_ent),
        .pop     (pop),
        .dout    (head),
        .full    (full),
        .empty   (empty),
        .level   (fifo_level)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b1;
            wea_q   <= 1'b0;
            addra_q <= '0;
            dia_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            wea_q   <= wea_d;
            addra_q <= addra_d;
            dia_q   <= dia_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q || (bus.host_wr_valid && full);
        wea_d   = 1'b0;
        addra_d = addra_q;
        dia_d   = dia_q;
        pop     = 1'b0;
        if (clear_req) begin
            // This edge only rearms the sweep. Address 0 is written on the next edge,
            // so every sweep writes exactly DEPTH addresses. Clear takes priority
            // over a pop, so the head entry stays in place.
            state_d = CLEAR;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                CLEAR: begin
                    wea_d   = 1'b1;
                    addra_d = cnt_q;
                    dia_d   = CLEAR_VALUE;
                    if (cnt_q == AW'(DEPTH-1)) begin
                        cnt_d   = '0;
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    if (!empty && drain_en) begin
                        pop     = 1'b1;
                        wea_d   = 1'b1;
                        addra_d = head.addr;
                        dia_d   = head.data;
                    end
                end
                default: state_d = CLEAR;
            endcase
        end
        // busy is aligned with wea, so it stays high for the final sweep write.
        busy_d = (state_q == CLEAR) || (state_d == CLEAR);
    end

    assign bus.host_wr_ready = !full;
    assign bus.wea           = wea_q;
    assign bus.addra         = addra_q;
    assign bus.dia           = dia_q;
    assign busy              = busy_q;
    assign overflow          = ovf_q;
endmodule

// File: tb/tb_opl3_reg_write_queue.sv
module tb_opl3_reg_write_queue;
    import opl3_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       drain_en, clear_req, busy, overflow;
    logic [4:0] fifo_level;
    int         checks = 0;
    int         errors = 0;

    opl3_reg_write_queue_if #(.AW(9), .DW(8)) bus ();

    opl3_reg_write_queue #(
        .DATA_WIDTH(8), .DEPTH(512), .FIFO_DEPTH(16), .CLEAR_VALUE(8'h00)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .drain_en   (drain_en),
        .clear_req  (clear_req),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // DEPTH consecutive sweep writes, starting at the next edge
    task automatic sweep_chk(input string tag);
        int bad = 0;
        for (int i = 0; i < 512; i++) begin
            step();
            if (!(bus.wea === 1'b1 && bus.addra === 9'(i) && bus.dia === 8'h00 && busy === 1'b1))
                bad++;
        end
        chk(tag, bad, 0);
    endtask

    task automatic push(input logic [8:0] a, input logic [7:0] d);
        bus.host_wr_valid = 1'b1;
        bus.host_addr     = a;
        bus.host_data     = d;
        step();
        bus.host_wr_valid = 1'b0;
    endtask

    initial begin
        int bad;
        int nw;
        reset_n = 1'b1;
        drain_en = 1'b0;
        clear_req = 1'b0;
        bus.host_wr_valid = 1'b0;
        bus.host_addr = '0;
        bus.host_data = '0;
        #1 reset_n = 1'b0;
        #1;
        chk("rst_wea", bus.wea, 0);
        chk("rst_addra", bus.addra, 0);
        chk("rst_dia", bus.dia, 0);
        chk("rst_busy", busy, 1);
        chk("rst_ready", bus.host_wr_ready, 1);
        chk("rst_ovf", overflow, 0);
        chk("rst_level", fifo_level, 0);
        step();
        reset_n = 1'b1;

        // power-up sweep
        sweep_chk("sweep0");
        step();
        chk("post_sweep_wea", bus.wea, 0);
        chk("post_sweep_busy", busy, 0);

        // single write latency
        drain_en = 1'b1;
        push(9'h0A0, 8'h5C);
        chk("lat_k_wea", bus.wea, 0);
        chk("lat_k_level", fifo_level, 1);
        step();
        chk("lat_k1_wea", bus.wea, 1);
        chk("lat_k1_addra", bus.addra, 9'h0A0);
        chk("lat_k1_dia", bus.dia, 8'h5C);
        chk("lat_k1_level", fifo_level, 0);
        step();
        chk("lat_k2_wea", bus.wea, 0);
        chk("lat_k2_addra_hold", bus.addra, 9'h0A0);

        // fill beyond capacity
        drain_en = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (i == 15) chk("ready_before_16th", bus.host_wr_ready, 1);
            if (i == 16) chk("ready_full", bus.host_wr_ready, 0);
            push(9'(i), 8'(i + 8'h10));
        end
        chk("full_level", fifo_level, 16);
        chk("full_ovf", overflow, 1);
        drain_en = 1'b1;
        bad = 0;
        for (int j = 0; j < 16; j++) begin
            step();
            if (!(bus.wea === 1'b1 && bus.addra === 9'(j) && bus.dia === 8'(j + 8'h10))) bad++;
        end
        chk("drain16_order", bad, 0);
        step();
        chk("drain16_dropped", bus.wea, 0);
        chk("drain16_level", fifo_level, 0);
        chk("ovf_sticky", overflow, 1);

        // clear_req after the second pop
        drain_en = 1'b0;
        for (int i = 0; i < 5; i++) push(9'(9'h100 + i), 8'(8'hA0 + i));
        chk("q5_level", fifo_level, 5);
        drain_en = 1'b1;
        step();
        chk("q5_pop0", bus.addra, 9'h100);
        step();
        chk("q5_pop1", {bus.wea, bus.addra, bus.dia}, {1'b1, 9'h101, 8'hA1});
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        chk("clr_wea", bus.wea, 0);
        chk("clr_busy", busy, 1);
        chk("clr_ovf", overflow, 0);
        chk("clr_level", fifo_level, 3);
        sweep_chk("sweep_clr");
        bad = 0;
        for (int i = 2; i < 5; i++) begin
            step();
            if (!(bus.wea === 1'b1 && bus.addra === 9'(9'h100 + i) && bus.dia === 8'(8'hA0 + i))) bad++;
        end
        chk("clr_resume", bad, 0);
        chk("clr_resume_busy", busy, 0);
        step();
        chk("clr_resume_end", bus.wea, 0);

        // alternating drain_en
        drain_en = 1'b0;
        for (int i = 0; i < 8; i++) push(9'(9'h040 + i), 8'(8'hC0 + i));
        bad = 0;
        nw = 0;
        for (int c = 0; c < 16; c++) begin
            drain_en = (c % 2 == 0);
            step();
            if (bus.wea === 1'b1) nw++;
            if (bus.wea !== (c % 2 == 0)) bad++;
            else if (c % 2 == 0 && !(bus.addra === 9'(9'h040 + c/2) && bus.dia === 8'(8'hC0 + c/2))) bad++;
        end
        chk("alt_pattern", bad, 0);
        chk("alt_count", nw, 8);

        // push during CLEAR is kept and issued after the sweep
        drain_en = 1'b1;
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        bus.host_wr_valid = 1'b1;
        bus.host_addr = 9'h1FF;
        bus.host_data = 8'h77;
        bad = 0;
        for (int i = 0; i < 512; i++) begin
            step();
            bus.host_wr_valid = 1'b0;
            if (i == 0) chk("clr_push_level", fifo_level, 1);
            if (!(bus.wea === 1'b1 && bus.addra === 9'(i) && bus.dia === 8'h00 && busy === 1'b1)) bad++;
        end
        chk("sweep_push", bad, 0);
        step();
        chk("clr_push_issue", {bus.wea, bus.addra, bus.dia}, {1'b1, 9'h1FF, 8'h77});

        // reset mid-sweep at address 200, with one entry queued
        drain_en = 1'b0;
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        bus.host_wr_valid = 1'b1;
        bus.host_addr = 9'h033;
        bus.host_data = 8'h99;
        for (int i = 0; i <= 200; i++) begin
            step();
            bus.host_wr_valid = 1'b0;
        end
        chk("mid_addra200", bus.addra, 200);
        chk("mid_level", fifo_level, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_wea", bus.wea, 0);
        chk("mid_rst_addra", bus.addra, 0);
        chk("mid_rst_dia", bus.dia, 0);
        chk("mid_rst_level", fifo_level, 0);
        chk("mid_rst_busy", busy, 1);
        step();
        reset_n = 1'b1;
        drain_en = 1'b1;
        sweep_chk("sweep_rst");
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus.wea !== 1'b0) bad++;
        end
        chk("rst_discard", bad, 0);
        chk("rst_discard_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
